// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the CPU data-memory port. It services single-word
// accesses qualified by chip select, write enable and byte enables. It contains:
//   - a word-addressed RAM (DEPTH_WORDS x 32) with byte-lane writes;
//   - a registered read path (data appears one cycle after the address);
//   - an MMIO window at the top of the word-address space:
//       all-ones - 2 : STATUS (bit0 = sticky ERR, write-1-to-clear)
//       all-ones - 1 : CYCLE  (free-running counter, read-only)
//       all-ones     : OUT    (general output register, byte-lane writable)
//   - a sticky error flag for unmapped accesses and illegal byte-enable patterns.
//
// Ports
//   CLK         in   1       clock, all state updates on posedge
//   RST         in   1       synchronous reset, active-high
//   MEM_CSN     in   1       chip select, active-low
//   MEM_WEN     in   1       write enable, active-low (1 = read)
//   MEM_ADDR    in   ADDR_W  word address
//   MEM_BE      in   4       byte enables; bit i selects bits [8i+7:8i]
//   MEM_WDATA   in   32      write data from CPU
//   MEM_RDATA   out  32      registered read data to CPU
//   OUTPUT_REG  out  32      OUT register contents
//   ERR         out  1       sticky access-error flag
//   dbg_state   out  1       access tracker state (0 = IDLE, 1 = ACCESS)
//
// Access protocol: there is no stall. Every posedge with MEM_CSN=0 is exactly
// one complete access; MEM_WEN selects read (1) or write (0). A read's data is
// on MEM_RDATA after that same edge. MEM_RDATA changes only on reads and reset.
// An access sampled together with RST=1 is dropped entirely.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MEM_CSN,
  input  logic              MEM_WEN,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [3:0]        MEM_BE,
  input  logic [31:0]       MEM_WDATA,
  output logic [31:0]       MEM_RDATA,
  output logic [31:0]       OUTPUT_REG,
  output logic              ERR,
  output logic              dbg_state
);

  localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // One extra bit so the RAM limit compare never truncates DEPTH_WORDS.
  localparam logic [ADDR_W:0]   RAM_LIMIT   = (ADDR_W+1)'(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_OUT    = '1;
  localparam logic [ADDR_W-1:0] ADDR_CYCLE  = ADDR_OUT - 1'b1;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_OUT - 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] cycle_q;
  logic [31:0] out_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic              rd, wr;
  logic              is_ram, is_status, is_cycle, is_out, is_mapped;
  logic              be_legal;
  logic              wr_ok;
  logic              ram_wr, out_wr;
  logic              err_set, err_clr;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       rd_word;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign rd = !MEM_CSN &&  MEM_WEN;
  assign wr = !MEM_CSN && !MEM_WEN;

  assign is_ram    = ({1'b0, MEM_ADDR} < RAM_LIMIT);
  assign is_status = (MEM_ADDR == ADDR_STATUS);
  assign is_cycle  = (MEM_ADDR == ADDR_CYCLE);
  assign is_out    = (MEM_ADDR == ADDR_OUT);
  assign is_mapped = is_ram || is_status || is_cycle || is_out;

  assign ram_idx = MEM_ADDR[RAM_AW-1:0];

  // Only naturally aligned byte, halfword and word lane patterns are accepted.
  always_comb begin
    be_legal = 1'b0;
    case (MEM_BE)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign wr_ok  = wr && be_legal;
  assign ram_wr = wr_ok && is_ram;
  assign out_wr = wr_ok && is_out;

  // A CYCLE write with legal lanes is a mapped no-op, so it raises no error.
  assign err_set = (rd && !is_mapped) || (wr && (!be_legal || !is_mapped));
  assign err_clr = wr_ok && is_status && MEM_BE[0] && MEM_WDATA[0];

  // ---------------------------------------------------------------------------
  // Read data selection
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    if (is_ram) begin
      rd_word = mem[ram_idx];
    end else if (is_status) begin
      rd_word = {31'd0, err_q};
    end else if (is_cycle) begin
      rd_word = cycle_q;
    end else if (is_out) begin
      rd_word = out_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM array (not reset; writes dropped during reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST && ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (MEM_BE[i]) begin
          mem[ram_idx][8*i +: 8] <= MEM_WDATA[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state: read data, OUT register, counter, error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
      out_q   <= '0;
      cycle_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // Wraps silently through zero.
      cycle_q <= cycle_q + 32'd1;

      // Unmapped reads load zero via the default arm of the read mux.
      if (rd) begin
        rdata_q <= rd_word;
      end

      if (out_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (MEM_BE[i]) begin
            out_q[8*i +: 8] <= MEM_WDATA[8*i +: 8];
          end
        end
      end

      // A new error takes priority over a clear in the same cycle.
      if (err_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Access tracker: IDLE while deselected, ACCESS while selected.
  // Purely observational; it gates nothing in the datapath.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!MEM_CSN) state_d = ST_ACCESS;
      ST_ACCESS: if (MEM_CSN)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign MEM_RDATA  = rdata_q;
  assign OUTPUT_REG = out_q;
  assign ERR        = err_q;
  assign dbg_state  = state_q;

endmodule
